// File: rtl/dino_score_counter.sv
// dino_score_counter: DIGITS-wide BCD run score with retained high score,
// IDLE/RUN/OVER game state, prescaled tick input and a multiplexed
// 7-segment display of either score or high score.
// Optional feature macro: SCORE_MILESTONE_EN adds a one-cycle 'milestone'
// pulse after each increment that lands on a multiple of 100.
module dino_score_counter #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 6,
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_tick,
    input  logic                  start,
    input  logic                  game_over,
    input  logic                  show_hi,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hi_score,
    output logic                  new_hi,
    output logic                  saturated,
    output logic                  running,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
`ifdef SCORE_MILESTONE_EN
   ,output logic                  milestone
`endif
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SW-1:0] ALL9 = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   score_q, score_d;
    logic [SW-1:0]   hi_q, hi_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            new_hi_q, new_hi_d;
    logic            sat_q, sat_d;
    logic            run_q, run_d;
    logic [CW-1:0]   scan_q, scan_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0] dsel_q, dsel_d;
    logic            inc;
    logic [SW-1:0]   inc_val;
    logic [SW-1:0]   disp;
    logic [3:0]      nib;

`ifdef SCORE_MILESTONE_EN
    localparam logic [SW-1:0] LOWMASK = SW'(8'hFF);
    logic ms_q, ms_d;
`endif

    // BCD +1 with ripple carry; a 9 wraps to 0 and carries on
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Game state, scoring and high-score next-state logic
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        hi_d     = hi_q;
        presc_d  = presc_q;
        new_hi_d = new_hi_q;
        sat_d    = sat_q;
        inc      = 1'b0;
        inc_val  = bcd_inc(score_q);
`ifdef SCORE_MILESTONE_EN
        ms_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d  = S_RUN;
                    score_d  = '0;
                    presc_d  = '0;
                    new_hi_d = 1'b0;
                    sat_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (start) begin
                    score_d  = '0;
                    presc_d  = '0;
                    new_hi_d = 1'b0;
                    sat_d    = 1'b0;
                end else if (game_over) begin
                    state_d = S_OVER;
                    if (score_q > hi_q) begin
                        hi_d     = score_q;
                        new_hi_d = 1'b1;
                    end
                end else if (game_tick) begin
                    if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        inc     = 1'b1;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (inc) begin
            if (score_q == ALL9) begin
                sat_d = 1'b1;
            end else begin
                score_d = inc_val;
                if (inc_val == ALL9) begin
                    sat_d = 1'b1;
                end
`ifdef SCORE_MILESTONE_EN
                ms_d = (DIGITS >= 3) && ((inc_val & LOWMASK) == '0);
`endif
            end
        end
        run_d = (state_d == S_RUN);
    end

    // Game state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            score_q  <= '0;
            hi_q     <= '0;
            presc_q  <= '0;
            new_hi_q <= 1'b0;
            sat_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            hi_q     <= hi_d;
            presc_q  <= presc_d;
            new_hi_q <= new_hi_d;
            sat_q    <= sat_d;
            run_q    <= run_d;
        end
    end

`ifdef SCORE_MILESTONE_EN
    // Milestone pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_q <= 1'b0;
        end else begin
            ms_q <= ms_d;
        end
    end

    assign milestone = ms_q;
`endif

    // Display scan: slot counter and rotating digit index
    always_comb begin
        scan_d = scan_q + CW'(1);
        idx_d  = idx_q;
        dsel_d = dsel_q;
        if (scan_q == CW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d  = '0;
                dsel_d = DIGITS'(1);
            end else begin
                idx_d  = idx_q + IW'(1);
                dsel_d = dsel_q << 1;
            end
        end
    end

    // Display scan registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
            dsel_q <= DIGITS'(1);
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
            dsel_q <= dsel_d;
        end
    end

    // Select the active digit and decode it to segments
    always_comb begin
        disp = show_hi ? hi_q : score_q;
        nib  = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                nib = disp[4*i +: 4];
            end
        end
        case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

    assign score     = score_q;
    assign hi_score  = hi_q;
    assign new_hi    = new_hi_q;
    assign saturated = sat_q;
    assign running   = run_q;
    assign dig_sel   = dsel_q;

endmodule

// File: tb/tb_dino_score_counter.sv
// Directed bench for dino_score_counter: instance A (TICK_DIV=6) covers
// runs, hi-score, priority and display scan; instance B (TICK_DIV=1)
// covers saturation and, with SCORE_MILESTONE_EN, the milestone pulse.
module tb_dino_score_counter;

    logic clk = 1'b0;
    logic rst;

    logic        a_tick, a_start, a_over, a_show;
    logic [15:0] a_score, a_hi;
    logic        a_new_hi, a_sat, a_run;
    logic [6:0]  a_seg;
    logic [3:0]  a_dig;

    logic        b_tick, b_start, b_over, b_show;
    logic [15:0] b_score, b_hi;
    logic        b_new_hi, b_sat, b_run;
    logic [6:0]  b_seg;
    logic [3:0]  b_dig;

`ifdef SCORE_MILESTONE_EN
    logic        a_ms, b_ms;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dino_score_counter #(.DIGITS(4), .TICK_DIV(6), .SCAN_DIV(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .game_tick (a_tick),
        .start     (a_start),
        .game_over (a_over),
        .show_hi   (a_show),
        .score     (a_score),
        .hi_score  (a_hi),
        .new_hi    (a_new_hi),
        .saturated (a_sat),
        .running   (a_run),
        .seg       (a_seg),
        .dig_sel   (a_dig)
`ifdef SCORE_MILESTONE_EN
       ,.milestone (a_ms)
`endif
    );

    dino_score_counter #(.DIGITS(4), .TICK_DIV(1), .SCAN_DIV(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .game_tick (b_tick),
        .start     (b_start),
        .game_over (b_over),
        .show_hi   (b_show),
        .score     (b_score),
        .hi_score  (b_hi),
        .new_hi    (b_new_hi),
        .saturated (b_sat),
        .running   (b_run),
        .seg       (b_seg),
        .dig_sel   (b_dig)
`ifdef SCORE_MILESTONE_EN
       ,.milestone (b_ms)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_ticks(input int n);
        a_tick = 1'b1;
        repeat (n) step();
        a_tick = 1'b0;
    endtask

    task automatic b_ticks(input int n);
        b_tick = 1'b1;
        repeat (n) step();
        b_tick = 1'b0;
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    task automatic a_pulse_over();
        a_over = 1'b1;
        step();
        a_over = 1'b0;
    endtask

    // Global time bound
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Directed stimulus and checks
    initial begin
        logic [6:0] exp_seg [4];
        logic [3:0] prev;
        logic       found;
        exp_seg[0] = 7'h66;
        exp_seg[1] = 7'h4F;
        exp_seg[2] = 7'h5B;
        exp_seg[3] = 7'h06;

        rst = 1'b1;
        a_tick = 0; a_start = 0; a_over = 0; a_show = 0;
        b_tick = 0; b_start = 0; b_over = 0; b_show = 0;
        step();
        step();

        // Reset values
        check("rst_score",   32'(a_score),  32'h0);
        check("rst_hi",      32'(a_hi),     32'h0);
        check("rst_running", 32'(a_run),    32'h0);
        check("rst_new_hi",  32'(a_new_hi), 32'h0);
        check("rst_sat",     32'(a_sat),    32'h0);
        check("rst_dig_sel", 32'(a_dig),    32'h1);
        check("rst_seg",     32'(a_seg),    32'h3F);
        rst = 1'b0;
        step();

        // Ticks in IDLE are ignored
        a_ticks(10);
        check("idle_ticks_score", 32'(a_score), 32'h0);
        check("idle_running",     32'(a_run),   32'h0);

        // First run: 60 ticks at /6 gives 10 points
        a_pulse_start();
        check("run1_running", 32'(a_run),   32'h1);
        a_ticks(60);
        check("run1_score",   32'(a_score), 32'h0010);
        check("run1_running2",32'(a_run),   32'h1);
        a_pulse_over();
        check("run1_over_running", 32'(a_run),    32'h0);
        check("run1_hi",           32'(a_hi),     32'h0010);
        check("run1_new_hi",       32'(a_new_hi), 32'h1);

        // Second run: lower score keeps hi-score
        a_pulse_start();
        check("run2_new_hi_clr", 32'(a_new_hi), 32'h0);
        check("run2_score_clr",  32'(a_score),  32'h0);
        a_ticks(30);
        check("run2_score",  32'(a_score), 32'h0005);
        a_pulse_over();
        check("run2_hi",     32'(a_hi),     32'h0010);
        check("run2_new_hi", 32'(a_new_hi), 32'h0);

        // Third run: equal score does not set new_hi
        a_pulse_start();
        a_ticks(60);
        check("run3_score",  32'(a_score), 32'h0010);
        a_pulse_over();
        check("run3_hi",     32'(a_hi),     32'h0010);
        check("run3_new_hi", 32'(a_new_hi), 32'h0);

        // game_over beats an incrementing tick
        a_pulse_start();
        a_ticks(5);
        check("prio_pre_score", 32'(a_score), 32'h0);
        a_tick = 1'b1;
        a_over = 1'b1;
        step();
        a_tick = 1'b0;
        a_over = 1'b0;
        check("prio_over_score",   32'(a_score),  32'h0);
        check("prio_over_running", 32'(a_run),    32'h0);
        check("prio_over_hi",      32'(a_hi),     32'h0010);

        // start beats game_over and clears the prescaler
        a_start = 1'b1;
        a_over  = 1'b1;
        step();
        a_start = 1'b0;
        a_over  = 1'b0;
        check("prio_start_running", 32'(a_run),   32'h1);
        check("prio_start_score",   32'(a_score), 32'h0);
        a_ticks(1);
        check("presc_cleared", 32'(a_score), 32'h0);
        a_ticks(5);
        check("presc_first_pt", 32'(a_score), 32'h0001);

        // Climb to 1234 for the display scan
        a_ticks(1233 * 6);
        check("scan_score", 32'(a_score), 32'h1234);

        found = 1'b0;
        prev  = a_dig;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (a_dig == 4'b0001 && prev != 4'b0001) found = 1'b1;
            prev = a_dig;
        end
        check("scan_align", 32'(found), 32'h1);

        for (int k = 0; k < 4; k++) begin
            check($sformatf("scan_dig%0d", k), 32'(a_dig), 32'(4'b0001 << k));
            check($sformatf("scan_seg%0d", k), 32'(a_seg), 32'(exp_seg[k]));
            if (k < 3) repeat (4) step();
        end

        // show_hi switches seg immediately (digit 3: hi=0, score=1)
        a_show = 1'b1;
        #1;
        check("show_hi_seg", 32'(a_seg), 32'h3F);
        a_show = 1'b0;
        #1;
        check("show_score_seg", 32'(a_seg), 32'h06);

        // Asynchronous reset mid-run
        rst = 1'b1;
        #1;
        check("arst_score",   32'(a_score),  32'h0);
        check("arst_hi",      32'(a_hi),     32'h0);
        check("arst_running", 32'(a_run),    32'h0);
        check("arst_new_hi",  32'(a_new_hi), 32'h0);
        check("arst_dig_sel", 32'(a_dig),    32'h1);
        check("arst_seg",     32'(a_seg),    32'h3F);
        step();
        rst = 1'b0;
        step();

        // Instance B: every tick scores
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_ticks(99);
        check("b_score_99", 32'(b_score), 32'h0099);
`ifdef SCORE_MILESTONE_EN
        check("b_ms_99", 32'(b_ms), 32'h0);
`endif
        b_ticks(1);
        check("b_score_100", 32'(b_score), 32'h0100);
`ifdef SCORE_MILESTONE_EN
        check("b_ms_100", 32'(b_ms), 32'h1);
`endif
        step();
`ifdef SCORE_MILESTONE_EN
        check("b_ms_100_end", 32'(b_ms), 32'h0);
`endif
        b_ticks(9898);
        check("b_score_9998", 32'(b_score), 32'h9998);
        check("b_sat_9998",   32'(b_sat),   32'h0);
        b_ticks(3);
        check("b_score_sat", 32'(b_score), 32'h9999);
        check("b_sat",       32'(b_sat),   32'h1);
`ifdef SCORE_MILESTONE_EN
        check("b_ms_sat", 32'(b_ms), 32'h0);
`endif
        b_over = 1'b1;
        step();
        b_over = 1'b0;
        check("b_hi",        32'(b_hi),     32'h9999);
        check("b_new_hi",    32'(b_new_hi), 32'h1);
        check("b_sat_over",  32'(b_sat),    32'h1);
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        check("b_sat_clr",   32'(b_sat),   32'h0);
        check("b_score_clr", 32'(b_score), 32'h0);
`ifdef SCORE_MILESTONE_EN
        check("b_ms_clr", 32'(b_ms), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
